// File: rtl/plane_hit_scheduler.sv
// Initiator-side sequencer for plane_ray_int: scans a plane table, issues one core
// transaction per enabled plane and returns the nearest positive hit. Optional watchdog: PLANE_HIT_TIMEOUT_EN.
module plane_hit_scheduler #(
    parameter  int unsigned NUM_PLANES  = 4,
    parameter  int unsigned TIMEOUT_CYC = 64,
    localparam int unsigned IDX_W       = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pl_we,
    input  logic [IDX_W-1:0] pl_addr,
    input  logic             pl_en,
    input  logic [95:0]      pl_p0,
    input  logic [95:0]      pl_nrm,
    input  logic             ray_valid,
    output logic             ray_ready,
    input  logic [95:0]      ray_p0,
    input  logic [95:0]      ray_dir,
    output logic             prim_start,
    output logic [95:0]      prim_ray_p0,
    output logic [95:0]      prim_ray_dir,
    output logic [95:0]      prim_plane_p0,
    output logic [95:0]      prim_plane_nrm,
    input  logic             prim_busy,
    input  logic             prim_valid,
    input  logic [31:0]      prim_t,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_hit,
    output logic [31:0]      res_t,
    output logic [IDX_W-1:0] res_idx,
    output logic             err_timeout
);
    localparam int unsigned VEC_W = 96;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [VEC_W-1:0]   ray_p0_q, ray_p0_d, ray_dir_q, ray_dir_d;
    logic [VEC_W-1:0]   pl_p0_q, pl_p0_d, pl_nrm_q, pl_nrm_d;
    logic               ray_ready_q, ray_ready_d, start_q, start_d;
    logic               res_valid_q, res_valid_d, hit_q, hit_d;
    logic [31:0]        best_t_q, best_t_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;

    logic               tbl_en_q  [NUM_PLANES];
    logic [VEC_W-1:0]   tbl_p0_q  [NUM_PLANES];
    logic [VEC_W-1:0]   tbl_nrm_q [NUM_PLANES];

    logic               wr_ok_c, t_is_hit_c, timeout_c, unused_c;

    assign unused_c   = ^{prim_busy, 32'(TIMEOUT_CYC)};
    assign wr_ok_c    = pl_we && (state_q == S_IDLE);
    // Strictly positive finite value: zero, negative, inf and NaN are misses.
    assign t_is_hit_c = !prim_t[31] && (prim_t[30:23] != 8'hFF) && (prim_t[30:0] != 31'd0);

`ifdef PLANE_HIT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             err_q, err_d;

    assign timeout_c = (state_q == S_WAIT) && !prim_valid && (wcnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        wcnt_d = '0;
        err_d  = err_q | timeout_c;
        if ((state_q == S_WAIT) && !prim_valid && !timeout_c) begin
            wcnt_d = wcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_c   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Plane table; enables cleared by reset, payload needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PLANES; i++) begin
                tbl_en_q[i] <= 1'b0;
            end
        end else if (wr_ok_c) begin
            tbl_en_q[pl_addr] <= pl_en;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            tbl_p0_q[pl_addr]  <= pl_p0;
            tbl_nrm_q[pl_addr] <= pl_nrm;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ray_p0_d   = ray_p0_q;
        ray_dir_d  = ray_dir_q;
        pl_p0_d    = pl_p0_q;
        pl_nrm_d   = pl_nrm_q;
        start_d    = 1'b0;
        hit_d      = hit_q;
        best_t_d   = best_t_q;
        best_idx_d = best_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (ray_valid && ray_ready_q) begin
                    ray_p0_d   = ray_p0;
                    ray_dir_d  = ray_dir;
                    idx_d      = '0;
                    best_t_d   = POS_INF;
                    best_idx_d = '0;
                    hit_d      = 1'b0;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (tbl_en_q[idx_q]) begin
                    start_d  = 1'b1;
                    pl_p0_d  = tbl_p0_q[idx_q];
                    pl_nrm_d = tbl_nrm_q[idx_q];
                    state_d  = S_WAIT;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_WAIT: begin
                if (prim_valid || timeout_c) begin
                    // Strict less-than keeps the lower index on ties.
                    if (prim_valid && t_is_hit_c && (prim_t < best_t_q)) begin
                        hit_d      = 1'b1;
                        best_t_d   = prim_t;
                        best_idx_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_SCAN;
                    end
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ray_ready_d = (state_d == S_IDLE);
        res_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            ray_p0_q    <= '0;
            ray_dir_q   <= '0;
            pl_p0_q     <= '0;
            pl_nrm_q    <= '0;
            ray_ready_q <= 1'b0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            best_t_q    <= POS_INF;
            best_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ray_p0_q    <= ray_p0_d;
            ray_dir_q   <= ray_dir_d;
            pl_p0_q     <= pl_p0_d;
            pl_nrm_q    <= pl_nrm_d;
            ray_ready_q <= ray_ready_d;
            start_q     <= start_d;
            res_valid_q <= res_valid_d;
            hit_q       <= hit_d;
            best_t_q    <= best_t_d;
            best_idx_q  <= best_idx_d;
        end
    end

    assign ray_ready      = ray_ready_q;
    assign prim_start     = start_q;
    assign prim_ray_p0    = ray_p0_q;
    assign prim_ray_dir   = ray_dir_q;
    assign prim_plane_p0  = pl_p0_q;
    assign prim_plane_nrm = pl_nrm_q;
    assign res_valid      = res_valid_q;
    assign res_hit        = hit_q;
    assign res_t          = best_t_q;
    assign res_idx        = best_idx_q;

endmodule

// File: tb/tb_plane_hit_scheduler.sv
// Bench for plane_hit_scheduler: table of ray scenarios against a latency model of
// plane_ray_int, results checked through an expected-result queue.
module tb_plane_hit_scheduler;
    localparam int unsigned NP = 4;
    localparam logic [31:0] INF = 32'h7F80_0000;

    typedef struct {
        string              name;
        logic [NP-1:0]      en;
        logic [NP-1:0][31:0] t;
        logic               exp_hit;
        logic [31:0]        exp_t;
        logic [1:0]         exp_idx;
        int                 exp_starts;
    } vec_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] t;
        logic [1:0]  idx;
    } res_rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pl_we, pl_en, ray_valid, ray_ready, prim_start, prim_busy, prim_valid;
    logic [1:0]  pl_addr, res_idx;
    logic [95:0] pl_p0, pl_nrm, ray_p0, ray_dir;
    logic [95:0] prim_ray_p0, prim_ray_dir, prim_plane_p0, prim_plane_nrm;
    logic [31:0] prim_t, res_t;
    logic        res_valid, res_ready, res_hit, err_timeout;

    int errors = 0;
    int checks = 0;

    res_rec_t            exp_q[$];
    logic [NP-1:0][31:0] cur_t;
    logic [NP-1:0]       cur_en;
    logic [NP-1:0]       no_resp;
    logic [95:0]         cur_ray_p0, cur_ray_dir;
    logic [383:0]        snap;
    int                  start_cnt = 0;
    int                  last_pidx = -1;
    bit                  pend = 0;
    int                  lat = 0;
    int                  pidx = 0;

    always #5 clk = ~clk;

    plane_hit_scheduler dut (
        .clk(clk), .rst(rst), .pl_we(pl_we), .pl_addr(pl_addr), .pl_en(pl_en),
        .pl_p0(pl_p0), .pl_nrm(pl_nrm), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_p0(ray_p0), .ray_dir(ray_dir), .prim_start(prim_start),
        .prim_ray_p0(prim_ray_p0), .prim_ray_dir(prim_ray_dir),
        .prim_plane_p0(prim_plane_p0), .prim_plane_nrm(prim_plane_nrm),
        .prim_busy(prim_busy), .prim_valid(prim_valid), .prim_t(prim_t),
        .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
        .res_t(res_t), .res_idx(res_idx), .err_timeout(err_timeout)
    );

    task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [95:0] p0_of(int i);
        return {32'h0, 32'hC0DE_0000 | 32'(i), 32'(i)};
    endfunction

    function automatic logic [95:0] nrm_of(int i);
        return {32'(i), 32'h0, 32'h3F80_0000};
    endfunction

    // Core model: answers each start after a per-plane latency unless muted.
    always @(negedge clk) begin
        prim_valid = 1'b0;
        if (rst) begin
            pend = 0;
        end else begin
            if (pend) begin
                if (lat == 0) begin
                    chk("prim_stable", 96'({prim_ray_p0, prim_ray_dir, prim_plane_p0, prim_plane_nrm} == snap), 96'd1);
                    prim_valid = 1'b1;
                    prim_t     = cur_t[pidx];
                    pend       = 0;
                end else begin
                    lat--;
                end
            end
            if (prim_start) begin
                start_cnt++;
                pidx = int'(prim_plane_p0[1:0]);
                chk("start_order", 96'((pidx > last_pidx) && cur_en[pidx]), 96'd1);
                chk("plane_data", {prim_plane_p0[63:0], prim_plane_nrm[95:64]},
                    {p0_of(pidx) & 96'h0000_0000_FFFF_FFFF_FFFF_FFFF, 32'(pidx)} & {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
                chk("ray_p0", prim_ray_p0, cur_ray_p0);
                chk("ray_dir", prim_ray_dir, cur_ray_dir);
                last_pidx = pidx;
                snap = {prim_ray_p0, prim_ray_dir, prim_plane_p0, prim_plane_nrm};
                if (!no_resp[pidx]) begin
                    pend = 1;
                    lat  = 1 + pidx;
                end
            end
        end
        prim_busy = pend;
    end

    task automatic wr_plane(int i, logic en);
        pl_we   = 1'b1;
        pl_addr = 2'(i);
        pl_en   = en;
        pl_p0   = p0_of(i);
        pl_nrm  = nrm_of(i);
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    task automatic send_ray(string nm);
        int n = 0;
        ray_p0      = {$urandom, $urandom, $urandom};
        ray_dir     = {$urandom, $urandom, $urandom};
        cur_ray_p0  = ray_p0;
        cur_ray_dir = ray_dir;
        start_cnt   = 0;
        last_pidx   = -1;
        ray_valid   = 1'b1;
        while (!ray_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".ray_accept"}, 96'(ray_ready), 96'd1);
        @(negedge clk);
        ray_valid = 1'b0;
        chk({nm, ".ray_ready_busy"}, 96'(ray_ready), 96'd0);
    endtask

    task automatic get_res(string nm, int hold);
        int n = 0;
        res_rec_t exp;
        logic [35:0] held;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            chk({nm, ".res_timeout"}, 96'(res_valid), 96'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        held = {res_valid, res_hit, res_t, res_idx};
        repeat (hold) begin
            @(negedge clk);
            chk({nm, ".res_stable"}, 96'({res_valid, res_hit, res_t, res_idx}), 96'(held));
            chk({nm, ".ray_ready_done"}, 96'(ray_ready), 96'd0);
        end
        if (exp_q.size() == 0) begin
            chk({nm, ".queue_empty"}, 96'd0, 96'd1);
            return;
        end
        exp = exp_q.pop_front();
        chk({nm, ".res_hit"}, 96'(res_hit), 96'(exp.hit));
        chk({nm, ".res_t"}, 96'(res_t), 96'(exp.t));
        chk({nm, ".res_idx"}, 96'(res_idx), 96'(exp.idx));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({nm, ".res_valid_drop"}, 96'(res_valid), 96'd0);
        chk({nm, ".ray_ready_back"}, 96'(ray_ready), 96'd1);
    endtask

    task automatic chk_reset(string nm);
        chk({nm, ".ray_ready"}, 96'(ray_ready), 96'd0);
        chk({nm, ".prim_start"}, 96'(prim_start), 96'd0);
        chk({nm, ".res_valid"}, 96'(res_valid), 96'd0);
        chk({nm, ".res_hit"}, 96'(res_hit), 96'd0);
        chk({nm, ".res_t"}, 96'(res_t), 96'(INF));
        chk({nm, ".res_idx"}, 96'(res_idx), 96'd0);
        chk({nm, ".err_timeout"}, 96'(err_timeout), 96'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        vecs[0] = '{"single",   4'b0001, {32'h0, 32'h0, 32'h0, 32'h3F80_0000},                       1'b1, 32'h3F80_0000, 2'd0, 1};
        vecs[1] = '{"two",      4'b0011, {32'h0, 32'h0, 32'h3F80_0000, 32'h4040_0000},               1'b1, 32'h3F80_0000, 2'd1, 2};
        vecs[2] = '{"tie_neg",  4'b0111, {32'h0, 32'hBF80_0000, 32'h4000_0000, 32'h4000_0000},       1'b1, 32'h4000_0000, 2'd0, 3};
        vecs[3] = '{"all_off",  4'b0000, {32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000}, 1'b0, INF, 2'd0, 0};
        vecs[4] = '{"specials", 4'b1111, {32'h8000_0001, 32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000}, 1'b0, INF, 2'd0, 4};
        vecs[5] = '{"sparse",   4'b1010, {32'h3E80_0000, 32'h3C00_0000, 32'h3F00_0000, 32'h3D00_0000}, 1'b1, 32'h3E80_0000, 2'd3, 2};
        vecs[6] = '{"denorm",   4'b1111, {32'h0000_0001, 32'h3F80_0000, 32'h7F7F_FFFF, 32'h0000_0001}, 1'b1, 32'h0000_0001, 2'd0, 4};
        vecs[7] = '{"last_max", 4'b1000, {32'h7F7F_FFFF, 32'h0, 32'h0, 32'h0},                       1'b1, 32'h7F7F_FFFF, 2'd3, 1};

        rst = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_en = 1'b0; pl_p0 = '0; pl_nrm = '0;
        ray_valid = 1'b0; ray_p0 = '0; ray_dir = '0; res_ready = 1'b0;
        prim_valid = 1'b0; prim_t = '0; prim_busy = 1'b0;
        cur_t = '0; cur_en = '0; no_resp = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 96'(ray_ready), 96'd1);

        foreach (vecs[v]) begin
            for (int i = 0; i < NP; i++) wr_plane(i, vecs[v].en[i]);
            cur_t   = vecs[v].t;
            cur_en  = vecs[v].en;
            no_resp = '0;
            exp_q.push_back('{vecs[v].exp_hit, vecs[v].exp_t, vecs[v].exp_idx});
            send_ray(vecs[v].name);
            get_res(vecs[v].name, (vecs[v].en == 4'b0000) ? 5 : 1);
            chk({vecs[v].name, ".starts"}, 96'(start_cnt), 96'(vecs[v].exp_starts));
        end
        chk("err_idle", 96'(err_timeout), 96'd0);

        // Table write while scanning must be dropped.
        for (int i = 0; i < NP; i++) wr_plane(i, i == 0);
        cur_t = {32'h0, 32'h0, 32'h3E00_0000, 32'h3F80_0000};
        cur_en = 4'b0001;
        no_resp = '0;
        exp_q.push_back('{1'b1, 32'h3F80_0000, 2'd0});
        send_ray("scan_wr");
        wr_plane(1, 1'b1);
        get_res("scan_wr", 1);
        chk("scan_wr.starts", 96'(start_cnt), 96'd1);

        // Reset while waiting on the core.
        for (int i = 0; i < NP; i++) wr_plane(i, i < 2);
        cur_t = {32'h0, 32'h0, 32'h3F80_0000, 32'h0};
        cur_en = 4'b0011;
        no_resp = 4'b0001;
        send_ray("rst_wait");
        n = 0;
        while (start_cnt < 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wait.started", 96'(start_cnt), 96'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("rst_wait");
        no_resp = '0;
        cur_en = '0;
        exp_q.push_back('{1'b0, INF, 2'd0});
        send_ray("cleared");
        get_res("cleared", 1);
        chk("cleared.starts", 96'(start_cnt), 96'd0);

`ifdef PLANE_HIT_TIMEOUT_EN
        for (int i = 0; i < NP; i++) wr_plane(i, i < 2);
        cur_t = {32'h0, 32'h0, 32'h3F80_0000, 32'h3E00_0000};
        cur_en = 4'b0011;
        no_resp = 4'b0001;
        exp_q.push_back('{1'b1, 32'h3F80_0000, 2'd1});
        send_ray("timeout");
        repeat (30) @(negedge clk);
        chk("timeout.err_early", 96'(err_timeout), 96'd0);
        get_res("timeout", 1);
        chk("timeout.starts", 96'(start_cnt), 96'd2);
        chk("timeout.err", 96'(err_timeout), 96'd1);
        repeat (3) @(negedge clk);
        chk("timeout.err_sticky", 96'(err_timeout), 96'd1);
        no_resp = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
